instruction_fetch_unit_porc2: RTL and testbench

- Front-end stage of the pORC2 core; feeds the instruction decoder directly.
- Holds the program counter and issues in-order requests to instruction memory.
- Buffers returned 16-bit instructions in a small queue and presents them one per cycle with a valid/ready handshake.
- On a branch/trap redirect, flushes wrong-path state and discards responses still in flight.

---
 rtl/instruction_fetch_unit_porc2_pkg.sv | 13 +
 rtl/instruction_fetch_unit_porc2_fifo.sv | 53 +++++
 rtl/instruction_fetch_unit_porc2.sv | 108 ++++++++++
 tb/tb_instruction_fetch_unit_porc2.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_porc2_pkg.sv
// Shared constants and entry layout for the pORC2 instruction fetch front end.
package pORC2_fetch_pkg;

  localparam int INSTRUCTIONWIDTH = 16;
  localparam logic [15:0] DEFAULT_RESETVECTOR = 16'h0000;

  // Queue entry layout at the default 16-bit PC width: instruction in the upper bits.
  typedef struct packed {
    logic [INSTRUCTIONWIDTH-1:0] instruction;
    logic [15:0]                 pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_porc2_fifo.sv
// Power-of-two ring buffer with synchronous flush; the caller never pushes when full
// or pops when empty, so no overflow protection is built in.
module FIFO_pORC2 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: head is only looked at while count is non-zero.
  always_ff @(posedge clk) begin
    if (en && push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit_porc2.sv
// pORC2 fetch stage: PC, credit-limited in-order memory requests, an instruction
// queue toward the decoder, and stale-response dropping after a redirect.
module instruction_fetch_unit_porc2
  import pORC2_fetch_pkg::*;
#(
  parameter int                      DATABITWIDTH = 16,
  parameter int                      QUEUEDEPTH   = 4,
  parameter logic [DATABITWIDTH-1:0] RESETVECTOR  = DATABITWIDTH'(DEFAULT_RESETVECTOR)
) (
  input  logic                        clk,
  input  logic                        async_rst_n,
  input  logic                        clk_en,
  output logic                        InstMemReqValid,
  input  logic                        InstMemReqReady,
  output logic [DATABITWIDTH-1:0]     InstMemReqAddr,
  input  logic                        InstMemRespValid,
  input  logic [INSTRUCTIONWIDTH-1:0] InstMemRespData,
  input  logic                        RedirectValid,
  input  logic [DATABITWIDTH-1:0]     RedirectAddr,
  input  logic                        DecoderReady,
  output logic                        FetchedInstructionValid,
  output logic [INSTRUCTIONWIDTH-1:0] FetchedInstruction,
  output logic [DATABITWIDTH-1:0]     FetchedInstructionPC
);

  localparam int CW = $clog2(QUEUEDEPTH + 1);
  localparam int EW = INSTRUCTIONWIDTH + DATABITWIDTH;

  logic [DATABITWIDTH-1:0] pc;
  logic [CW-1:0]           stale;
  logic [CW-1:0]           outstanding;
  logic [CW-1:0]           q_count;
  logic [CW:0]             credit_used;
  logic [EW-1:0]           q_head;
  logic [DATABITWIDTH-1:0] inflight_pc;
  logic                    allowed;
  logic                    req_fire;
  logic                    resp;
  logic                    drop;
  logic                    enq;
  logic                    deq;
  logic                    flush;

  // Handshake rule on both sides: a transfer happens only in a cycle where valid
  // and ready are both high with clk_en high; valid never waits on ready.
  assign flush       = clk_en & RedirectValid;
  assign resp        = clk_en & InstMemRespValid;
  assign drop        = resp & ((stale != '0) | RedirectValid);
  assign enq         = resp & ~drop;

  // Live in-flight requests (outstanding minus stale) reserve queue slots.
  assign credit_used = {1'b0, q_count} + {1'b0, outstanding} - {1'b0, stale};
  assign allowed     = (credit_used < (CW+1)'(QUEUEDEPTH)) && (outstanding < CW'(QUEUEDEPTH));

  assign InstMemReqValid = allowed & clk_en & ~RedirectValid & async_rst_n;
  assign InstMemReqAddr  = pc;
  assign req_fire        = InstMemReqValid & InstMemReqReady;

  assign FetchedInstructionValid = (q_count != '0) & clk_en & ~RedirectValid;
  assign deq                     = FetchedInstructionValid & DecoderReady;
  assign FetchedInstruction      = FetchedInstructionValid ? q_head[EW-1 -: INSTRUCTIONWIDTH] : '0;
  assign FetchedInstructionPC    = FetchedInstructionValid ? q_head[DATABITWIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      pc    <= RESETVECTOR;
      stale <= '0;
    end else if (clk_en) begin
      if (RedirectValid) begin
        pc    <= RedirectAddr;
        stale <= outstanding - CW'(resp);
      end else begin
        if (req_fire)               pc    <= pc + 1'b1;
        if (resp && stale != '0)    stale <= stale - 1'b1;
      end
    end
  end

  // Address FIFO is never flushed: stale responses still retire their own entry,
  // and its count is the outstanding-request counter.
  FIFO_pORC2 #(.WIDTH(DATABITWIDTH), .DEPTH(QUEUEDEPTH)) u_addr_fifo (
    .clk       (clk),
    .rst_n     (async_rst_n),
    .en        (clk_en),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc),
    .pop       (resp),
    .head      (inflight_pc),
    .count     (outstanding)
  );

  FIFO_pORC2 #(.WIDTH(EW), .DEPTH(QUEUEDEPTH)) u_inst_queue (
    .clk       (clk),
    .rst_n     (async_rst_n),
    .en        (clk_en),
    .flush     (flush),
    .push      (enq),
    .push_data ({InstMemRespData, inflight_pc}),
    .pop       (deq),
    .head      (q_head),
    .count     (q_count)
  );

  resp_needs_request: assert property (@(posedge clk) disable iff (!async_rst_n)
    resp |-> (outstanding != '0));

endmodule

// File: tb/tb_instruction_fetch_unit_porc2.sv
// Directed bench for instruction_fetch_unit_porc2: in-order memory model,
// expected-PC scoreboard and hand-computed cycle checks.
module tb_instruction_fetch_unit_porc2;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        decoder_ready;
  logic        fi_valid;
  logic [15:0] fi_instr;
  logic [15:0] fi_pc;

  logic        w_req_valid;
  logic [15:0] w_req_addr;
  logic        w_fi_valid;
  logic [15:0] w_fi_instr;
  logic [15:0] w_fi_pc;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int mem_t = 0;
  int lat = 1;
  int n_issued = 0;
  int n_deq = 0;
  int first_valid_cyc = -1;
  int max_inflight = 0;
  int snap = 0;
  int r = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mq_addr[$];
  int          mq_due[$];

  instruction_fetch_unit_porc2 #(.DATABITWIDTH(16), .QUEUEDEPTH(4), .RESETVECTOR(16'h0000)) dut (
    .clk                     (clk),
    .async_rst_n             (rst_n),
    .clk_en                  (clk_en),
    .InstMemReqValid         (req_valid),
    .InstMemReqReady         (req_ready),
    .InstMemReqAddr          (req_addr),
    .InstMemRespValid        (resp_valid),
    .InstMemRespData         (resp_data),
    .RedirectValid           (redirect_valid),
    .RedirectAddr            (redirect_addr),
    .DecoderReady            (decoder_ready),
    .FetchedInstructionValid (fi_valid),
    .FetchedInstruction      (fi_instr),
    .FetchedInstructionPC    (fi_pc)
  );

  // Second instance only exercises the reset vector and address wrap; memory never answers.
  instruction_fetch_unit_porc2 #(.DATABITWIDTH(16), .QUEUEDEPTH(4), .RESETVECTOR(16'hFFFE)) u_wrap (
    .clk                     (clk),
    .async_rst_n             (rst_n),
    .clk_en                  (1'b1),
    .InstMemReqValid         (w_req_valid),
    .InstMemReqReady         (1'b1),
    .InstMemReqAddr          (w_req_addr),
    .InstMemRespValid        (1'b0),
    .InstMemRespData         (16'h0000),
    .RedirectValid           (1'b0),
    .RedirectAddr            (16'h0000),
    .DecoderReady            (1'b1),
    .FetchedInstructionValid (w_fi_valid),
    .FetchedInstruction      (w_fi_instr),
    .FetchedInstructionPC    (w_fi_pc)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish within time budget");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5AC3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic load_exp(input logic [15:0] start);
    exp_q.delete();
    for (int i = 0; i < 96; i++) exp_q.push_back(start + 16'(i));
  endtask

  // ---------------- driver tasks ----------------
  task automatic mem_drive();
    resp_valid = 1'b0;
    resp_data  = 16'h0000;
    if (rst_n && !clk_en) begin
      // Garbage response while gated: must not be sampled.
      resp_valid = 1'b1;
      resp_data  = 16'hDEAD;
    end else if (rst_n && mq_addr.size() > 0 && mq_due[0] <= mem_t) begin
      resp_valid = 1'b1;
      resp_data  = instr_of(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
  endtask

  task automatic mem_sample();
    if (rst_n && clk_en && req_valid && req_ready) begin
      mq_addr.push_back(req_addr);
      mq_due.push_back(mem_t + lat);
      n_issued++;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic sb_sample();
    if (rst_n && fi_valid && decoder_ready) begin
      n_deq++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_pc", {16'h0, fi_pc}, 32'hFFFF_FFFF);
      end else begin
        check_eq("sb_pc", {16'h0, fi_pc}, {16'h0, exp_q[0]});
        check_eq("sb_instr", {16'h0, fi_instr}, {16'h0, instr_of(exp_q[0])});
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic begin_cycle();
    mem_drive();
    #1;
  endtask

  task automatic end_cycle();
    mem_sample();
    sb_sample();
    @(negedge clk);
    cyc++;
    if (clk_en) mem_t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      end_cycle();
    end
  endtask

  task automatic wait_first_valid(input int budget);
    for (int i = 0; i < budget && first_valid_cyc < 0; i++) run(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; clk_en = 1'b1; req_ready = 1'b1;
    resp_valid = 1'b0; resp_data = 16'h0000;
    redirect_valid = 1'b0; redirect_addr = 16'h0000;
    decoder_ready = 1'b1; lat = 1;
    load_exp(16'h0000);

    @(negedge clk); #1;
    check_eq("rst_req_valid", req_valid, 0);
    check_eq("rst_fi_valid", fi_valid, 0);
    check_eq("rst_fi_instr", fi_instr, 0);
    check_eq("rst_fi_pc", fi_pc, 0);
    check_eq("rst_req_addr", req_addr, 0);
    check_eq("rst_wrap_req_valid", w_req_valid, 0);
    @(negedge clk);

    // Stream, latency 1, decoder always ready.
    rst_n = 1'b1; cyc = 1; mem_t = 0; first_valid_cyc = -1;
    begin_cycle();
    check_eq("first_req_valid", req_valid, 1);
    check_eq("first_req_addr", req_addr, 16'h0000);
    check_eq("wrap_addr_0", w_req_addr, 16'hFFFE);
    end_cycle();
    begin_cycle();
    check_eq("second_req_addr", req_addr, 16'h0001);
    check_eq("c2_fi_valid", fi_valid, 0);
    check_eq("wrap_addr_1", w_req_addr, 16'hFFFF);
    end_cycle();
    begin_cycle();
    check_eq("c3_fi_valid", fi_valid, 1);
    check_eq("wrap_addr_2", w_req_addr, 16'h0000);
    end_cycle();
    begin_cycle();
    check_eq("wrap_addr_3", w_req_addr, 16'h0001);
    end_cycle();
    begin_cycle();
    check_eq("wrap_credit_stop", w_req_valid, 0);
    end_cycle();
    run(7);
    check_eq("first_valid_cycle", first_valid_cyc, 3);
    check_eq("stream_deq_count", n_deq, 10);

    // Backpressure: decoder stalls cycles 13..22.
    decoder_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      begin_cycle();
      if (i == 9) begin
        check_eq("bp_req_dropped", req_valid, 0);
        check_eq("bp_head_valid", fi_valid, 1);
        check_eq("bp_head_pc", fi_pc, 16'h000A);
      end
      end_cycle();
      if (n_issued - n_deq > max_inflight) max_inflight = n_issued - n_deq;
    end
    check_eq("bp_max_inflight", max_inflight, 4);
    check_eq("bp_no_deq", n_deq, 10);
    decoder_ready = 1'b1;
    begin_cycle();
    check_eq("bp_resume_full_no_req", req_valid, 0);
    end_cycle();
    run(10);

    // Redirect with three requests in flight, latency 3.
    lat = 3;
    req_ready = 1'b0;
    run(6);
    req_ready = 1'b1;
    run(3);
    redirect_valid = 1'b1; redirect_addr = 16'h0100;
    load_exp(16'h0100); first_valid_cyc = -1; r = cyc;
    begin_cycle();
    check_eq("redir_no_req", req_valid, 0);
    check_eq("redir_no_deq", fi_valid, 0);
    end_cycle();
    redirect_valid = 1'b0;
    begin_cycle();
    check_eq("redir_next_req_valid", req_valid, 1);
    check_eq("redir_next_req_addr", req_addr, 16'h0100);
    end_cycle();
    wait_first_valid(20);
    check_eq("redir_first_valid_cycle", first_valid_cyc, r + 5);
    run(4);

    // Redirect coincident with a response, latency 2, two in flight.
    lat = 2;
    req_ready = 1'b0;
    run(6);
    req_ready = 1'b1;
    run(2);
    redirect_valid = 1'b1; redirect_addr = 16'h0200;
    load_exp(16'h0200); first_valid_cyc = -1; r = cyc;
    begin_cycle();
    check_eq("coinc_no_deq", fi_valid, 0);
    end_cycle();
    redirect_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      begin_cycle();
      check_eq("coinc_queue_empty", fi_valid, 0);
      end_cycle();
    end
    wait_first_valid(20);
    check_eq("coinc_first_valid_cycle", first_valid_cyc, r + 4);

    // clk_en gating mid-stream.
    lat = 1;
    run(8);
    snap = n_deq;
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      begin_cycle();
      check_eq("gated_req_valid", req_valid, 0);
      check_eq("gated_fi_valid", fi_valid, 0);
      end_cycle();
    end
    check_eq("gated_no_deq", n_deq, snap);
    clk_en = 1'b1;
    run(10);

    // Asynchronous reset mid-stream.
    rst_n = 1'b0;
    #1;
    check_eq("midrst_req_valid", req_valid, 0);
    check_eq("midrst_fi_valid", fi_valid, 0);
    check_eq("midrst_fi_instr", fi_instr, 0);
    check_eq("midrst_fi_pc", fi_pc, 0);
    mq_addr.delete(); mq_due.delete();
    load_exp(16'h0000);
    resp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; cyc = 1; first_valid_cyc = -1;
    begin_cycle();
    check_eq("restart_req_valid", req_valid, 1);
    check_eq("restart_req_addr", req_addr, 16'h0000);
    end_cycle();
    run(5);
    check_eq("restart_first_valid_cycle", first_valid_cyc, 3);
    check_eq("wrap_no_fetch_valid", w_fi_valid, 0);
    check_eq("wrap_no_fetch_pc", {w_fi_instr, w_fi_pc}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
